// File: rtl/hydra_pkg.sv
// rtl/hydra_pkg.sv - shared widths and page metadata for the write-side datapath
package hydra_pkg;
  localparam int DATA_W = 16;
  localparam int WORDS  = 8;
  localparam int PAGE_W = DATA_W * WORDS;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             last;
  } page_meta_t;
endpackage

// File: rtl/page_fifo.sv
// rtl/page_fifo.sv - 2-entry valid/ready page queue with the head held in output registers
module page_fifo
  import hydra_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_vld,
  input  logic [PAGE_W-1:0] push_data,
  input  page_meta_t        push_meta,
  output logic              full,
  output logic              pop_vld,
  input  logic              pop_rdy,
  output logic [PAGE_W-1:0] pop_data,
  output page_meta_t        pop_meta
);
  logic [1:0]        count;
  logic [PAGE_W-1:0] tail_data;
  page_meta_t        tail_meta;
  logic              push, pop;

  assign full    = (count == 2'd2);
  assign pop_vld = (count != 2'd0);
  assign pop     = pop_vld && pop_rdy;
  assign push    = push_vld && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      pop_data  <= '0;
      pop_meta  <= '0;
      tail_data <= '0;
      tail_meta <= '0;
    end else begin
      // The head register drives the outputs; the tail only parks the second page.
      if (pop) begin
        if (count == 2'd2) begin
          pop_data <= tail_data;
          pop_meta <= tail_meta;
        end else if (push) begin
          pop_data <= push_data;
          pop_meta <= push_meta;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          pop_data <= push_data;
          pop_meta <= push_meta;
        end else begin
          tail_data <= push_data;
          tail_meta <= push_meta;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/port_packer.sv
// rtl/port_packer.sv - packs parser payload words into 128-bit pages and queues them
module port_packer #(
  parameter int DATA_W = hydra_pkg::DATA_W,
  parameter int WORDS  = hydra_pkg::WORDS,
  parameter int CNT_W  = hydra_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_rdy,
  output logic                    page_vld,
  input  logic                    page_rdy,
  output logic [DATA_W*WORDS-1:0] page_data,
  output logic [CNT_W-1:0]        page_cnt,
  output logic                    page_first,
  output logic                    page_last,
  output logic                    drop,
  output logic                    proto_err
);
  import hydra_pkg::*;

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [IDX_W-1:0]        idx, eff_idx;
  logic [DATA_W-1:0]       slots [WORDS];
  logic                    asm_first;
  logic                    accept, restart, commit, fifo_full;
  logic [DATA_W*WORDS-1:0] asm_page;
  page_meta_t              asm_meta, head_meta;

  assign in_rdy  = !fifo_full;
  assign accept  = in_vld && in_rdy;
  // Only reachable mid-page: a word carrying in_last always commits, so asm_last never lingers.
  assign restart = accept && in_first && (idx != '0);
  assign eff_idx = restart ? '0 : idx;
  assign commit  = accept && (in_last || (eff_idx == LAST_IDX));

  always_comb begin
    asm_page = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (k < int'(eff_idx))
        asm_page[k*DATA_W +: DATA_W] = slots[k];
      else if (k == int'(eff_idx))
        asm_page[k*DATA_W +: DATA_W] = in_data;
    end
  end

  assign asm_meta = {CNT_W'(eff_idx) + CNT_W'(1), in_first || (asm_first && !restart), in_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      asm_first <= 1'b0;
      drop      <= 1'b0;
      proto_err <= 1'b0;
      for (int k = 0; k < WORDS; k++) slots[k] <= '0;
    end else begin
      drop      <= in_vld && !in_rdy;
      proto_err <= restart;
      if (accept) begin
        slots[eff_idx] <= in_data;
        if (commit) begin
          idx       <= '0;
          asm_first <= 1'b0;
        end else begin
          idx       <= eff_idx + IDX_W'(1);
          asm_first <= in_first || (asm_first && !restart);
        end
      end
    end
  end

  page_fifo u_page_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_vld  (commit),
    .push_data (asm_page),
    .push_meta (asm_meta),
    .full      (fifo_full),
    .pop_vld   (page_vld),
    .pop_rdy   (page_rdy),
    .pop_data  (page_data),
    .pop_meta  (head_meta)
  );

  assign page_cnt   = head_meta.cnt;
  assign page_first = head_meta.first;
  assign page_last  = head_meta.last;
endmodule

// File: tb/tb_port_packer.sv
// tb/tb_port_packer.sv - randomized self-checking bench for port_packer
module tb_port_packer;
  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   cnt;
    logic         first;
    logic         last;
  } page_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_vld = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_rdy, page_vld, page_rdy = 1'b0;
  logic [127:0] page_data;
  logic [3:0]   page_cnt;
  logic         page_first, page_last, drop, proto_err;

  int    n_cmp = 0, n_bad = 0;
  page_t got[$], exp[$];
  logic [15:0] cur[$];
  logic  cur_first;
  int    occ, drop_seen, drop_exp, proto_seen, proto_exp;

  always #5 clk = ~clk;

  port_packer dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_first(in_first), .in_last(in_last),
    .in_data(in_data), .in_rdy(in_rdy), .page_vld(page_vld), .page_rdy(page_rdy),
    .page_data(page_data), .page_cnt(page_cnt), .page_first(page_first),
    .page_last(page_last), .drop(drop), .proto_err(proto_err)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (page_vld && page_rdy) got.push_back({page_data, page_cnt, page_first, page_last});
      if (drop) drop_seen++;
      if (proto_err) proto_seen++;
    end
  end

  // Reference: words of a packet are chunked into pages of at most 8; a fresh first discards a partial.
  task automatic model_edge();
    bit    rdy = (occ < 2);
    bit    pop = (occ > 0) && page_rdy;
    page_t p;
    if (in_vld && !rdy) drop_exp++;
    if (in_vld && rdy) begin
      if (in_first && cur.size() != 0) begin
        cur.delete();
        cur_first = 1'b0;
        proto_exp++;
      end
      cur.push_back(in_data);
      cur_first = cur_first | in_first;
      if (in_last || cur.size() == 8) begin
        p = '0;
        foreach (cur[k]) p.data[k*16 +: 16] = cur[k];
        p.cnt   = 4'(cur.size());
        p.first = cur_first;
        p.last  = in_last;
        exp.push_back(p);
        cur.delete();
        cur_first = 1'b0;
        occ++;
      end
    end
    if (pop) occ--;
  endtask

  task automatic cycle(input bit v, input bit f, input bit l, input logic [15:0] d);
    in_vld = v; in_first = f; in_last = l; in_data = d;
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic clear_logs();
    got.delete(); exp.delete();
    drop_seen = 0; drop_exp = 0; proto_seen = 0; proto_exp = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; occ = 0; cur.delete(); cur_first = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++;
    if ({in_rdy, page_vld, page_data, page_cnt, page_first, page_last, drop, proto_err} !== {1'b1, 1'b0, 128'h0, 4'h0, 4'b0000}) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b vld=%b data=%h cnt=%0d f=%b l=%b drop=%b perr=%b, want rdy=1 rest 0",
               in_rdy, page_vld, page_data, page_cnt, page_first, page_last, drop, proto_err);
    end
  endtask

  task automatic test_eight_word();
    clear_logs(); page_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, i == 0, i == 7, 16'(i + 1));
      if (i == 6) begin
        n_cmp++;
        if (page_vld !== 1'b0) begin n_bad++; $display("FAIL eight_early_vld: got %b want 0", page_vld); end
      end
    end
    n_cmp++;
    if ({page_vld, page_data, page_cnt, page_first, page_last} !== {1'b1, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 4'd8, 2'b11}) begin
      n_bad++;
      $display("FAIL eight_page: vld=%b data=%h cnt=%0d f=%b l=%b want vld=1 data=00080007..0001 cnt=8 f=1 l=1",
               page_vld, page_data, page_cnt, page_first, page_last);
    end
    page_rdy = 1'b1; idle(); idle();
    n_cmp++;
    if (got.size() !== 1 || page_vld !== 1'b0) begin n_bad++; $display("FAIL eight_pop: pages=%0d vld=%b want 1 page vld=0", got.size(), page_vld); end
  endtask

  task automatic test_three_word();
    logic [15:0] w [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    clear_logs(); page_rdy = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, i == 0, i == 2, w[i]);
    n_cmp++;
    if ({page_vld, page_data[47:0], page_data[127:48], page_cnt, page_first, page_last} !== {1'b1, 48'hCCCC_BBBB_AAAA, 80'h0, 4'd3, 2'b11}) begin
      n_bad++;
      $display("FAIL three_page: vld=%b data=%h cnt=%0d f=%b l=%b want data=...CCCCBBBBAAAA cnt=3 f=1 l=1",
               page_vld, page_data, page_cnt, page_first, page_last);
    end
    idle(); idle();
    n_cmp++;
    if (got.size() !== 1) begin n_bad++; $display("FAIL three_count: got %0d pages want 1", got.size()); end
  endtask

  task automatic test_twenty_word();
    logic [3:0] cnts [3] = '{4'd8, 4'd8, 4'd4};
    logic [2:0] fl   = 3'b100;
    logic [2:0] ll   = 3'b001;
    clear_logs(); page_rdy = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b1, i == 0, i == 19, 16'($urandom));
    repeat (3) idle();
    n_cmp++;
    if (got.size() !== 3) begin n_bad++; $display("FAIL twenty_count: got %0d pages want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i] || got[i].cnt !== cnts[i] || got[i].first !== fl[2-i] || got[i].last !== ll[2-i]) begin
        n_bad++;
        $display("FAIL twenty_page%0d: got cnt=%0d f=%b l=%b data=%h want cnt=%0d f=%b l=%b data=%h",
                 i, got[i].cnt, got[i].first, got[i].last, got[i].data, cnts[i], fl[2-i], ll[2-i], exp[i].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs(); page_rdy = 1'b0;
    for (int j = 0; j < 24; j++) begin
      cycle(1'b1, (j % 8) == 0, (j % 8) == 7, 16'($urandom));
      n_cmp++;
      if (in_rdy !== ((j + 1) < 16)) begin n_bad++; $display("FAIL b2b_in_rdy word %0d: got %b want %b", j, in_rdy, (j + 1) < 16); end
    end
    idle();
    n_cmp++;
    if (drop_seen !== 8) begin n_bad++; $display("FAIL b2b_drops: got %0d want 8", drop_seen); end
    page_rdy = 1'b1;
    repeat (4) idle();
    n_cmp++;
    if (got.size() !== 2 || exp.size() !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d pages want 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size() && i < exp.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin n_bad++; $display("FAIL b2b_order%0d: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++;
    if (in_rdy !== 1'b1 || page_vld !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: rdy=%b vld=%b want 1/0", in_rdy, page_vld); end
  endtask

  task automatic test_proto();
    clear_logs(); page_rdy = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, i == 0, 1'b0, 16'(16'h4000 + i));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, i == 0, i == 2, 16'(16'h5001 + i));
      if (i == 0) begin
        n_cmp++;
        if (proto_err !== 1'b1) begin n_bad++; $display("FAIL proto_pulse: got %b want 1", proto_err); end
      end
    end
    idle(); idle();
    n_cmp++;
    if (proto_seen !== 1) begin n_bad++; $display("FAIL proto_count: got %0d pulses want 1", proto_seen); end
    n_cmp++;
    if (got.size() !== 1) begin n_bad++; $display("FAIL proto_pages: got %0d want 1", got.size()); end
    else begin
      n_cmp++;
      if (got[0] !== {128'h5003_5002_5001, 4'd3, 2'b11}) begin n_bad++; $display("FAIL proto_page: got %h want cnt=3 f=1 l=1 data=500350025001", got[0]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs(); page_rdy = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 16'h1234);
    for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, 1'b0, 16'(16'h2000 + i));
    in_vld = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({page_vld, in_rdy, page_cnt} !== {1'b0, 1'b1, 4'd0}) begin
      n_bad++; $display("FAIL reset_async: vld=%b rdy=%b cnt=%0d want 0/1/0", page_vld, in_rdy, page_cnt);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    occ = 0; cur.delete(); cur_first = 1'b0; clear_logs();
    page_rdy = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 16'h7777);
    idle(); idle();
    n_cmp++;
    if (got.size() !== 1) begin n_bad++; $display("FAIL reset_after_pages: got %0d want 1", got.size()); end
    else begin
      n_cmp++;
      if (got[0] !== {128'h7777, 4'd1, 2'b11}) begin n_bad++; $display("FAIL reset_after_page: got %h want data=7777 cnt=1 f=1 l=1", got[0]); end
    end
  endtask

  task automatic test_random();
    int left = 0, len = 0;
    clear_logs();
    for (int c = 0; c < 600; c++) begin
      page_rdy = 1'($urandom_range(0, 1));
      n_cmp++;
      if (in_rdy !== (occ < 2)) begin n_bad++; $display("FAIL random_in_rdy cycle %0d: got %b want %b", c, in_rdy, occ < 2); end
      if ($urandom_range(0, 3) == 0) begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      end else begin
        if (left == 0) begin len = $urandom_range(1, 20); left = len; end
        cycle(1'b1, left == len, left == 1, 16'($urandom));
        left--;
      end
    end
    page_rdy = 1'b1;
    repeat (4) idle();
    n_cmp++;
    if (got.size() !== exp.size()) begin n_bad++; $display("FAIL random_count: got %0d pages want %0d", got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin n_bad++; $display("FAIL random_page%0d: got %h want %h", i, got[i], exp[i]); end
    end
    n_cmp++;
    if (drop_seen !== drop_exp || proto_seen !== proto_exp) begin
      n_bad++; $display("FAIL random_pulses: drops %0d/%0d proto %0d/%0d (got/want)", drop_seen, drop_exp, proto_seen, proto_exp);
    end
  endtask

  initial begin
    test_reset();
    test_eight_word();
    test_three_word();
    test_twenty_word();
    test_back_to_back();
    test_proto();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
